// File: rtl/fir_cfg_ctrl.sv
// rtl/fir_cfg_ctrl.sv - FIR coefficient shadow RAM and drain/reload controller
// Optional shadow readback port pair enabled by defining FIR_CFG_READBACK_EN.
module fir_cfg_ctrl #(
  parameter real TCQ           = 0.1,
  parameter int  FIR_TAP_WIDTH = 32,
  parameter int  FIR_TAP_NUM   = 79,
  parameter int  DS_MAX        = 19,
  parameter int  DRAIN_CYCLES  = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cfg_wr_i,
  input  logic [9:0]               cfg_addr_i,
  input  logic [FIR_TAP_WIDTH-1:0] cfg_data_i,
  input  logic [7:0]               cfg_ds_i,
  input  logic                     cfg_commit_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  input  logic                     s_axis_tvalid_i,
  output logic                     s_axis_tready_o,
  output logic                     fir_s_tvalid_o,
  input  logic                     fir_s_tready_i,
  input  logic                     fir_m_tvalid_i,
  output logic                     fir_tap_vld_o,
  output logic [9:0]               fir_tap_addr_o,
  output logic [FIR_TAP_WIDTH-1:0] fir_tap_data_o,
`ifdef FIR_CFG_READBACK_EN
  input  logic [9:0]               rd_addr_i,
  output logic [FIR_TAP_WIDTH-1:0] rd_data_o,
`endif
  output logic [7:0]               fir_down_sample_num_o
);

  localparam int AW = (FIR_TAP_NUM > 1) ? $clog2(FIR_TAP_NUM) : 1;
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DRAIN_CYCLES);
  localparam logic [9:0]    TAP_NUM_L = 10'(FIR_TAP_NUM);
  localparam logic [7:0]    DS_MAX_L  = 8'(DS_MAX);

  if (TCQ < 0.0 || DRAIN_CYCLES < 1 || DS_MAX > 255 || FIR_TAP_NUM > 1024) begin : g_param_check
    $error("fir_cfg_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD, DSUPD} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [9:0]               idx_q, idx_d;
  logic [7:0]               ds_lat_q, ds_lat_d;
  logic [7:0]               ds_q, ds_d;
  logic                     tap_vld_q, tap_vld_d;
  logic [9:0]               tap_addr_q, tap_addr_d;
  logic [FIR_TAP_WIDTH-1:0] tap_data_q, tap_data_d;
  logic                     err_q, err_d;
  logic                     shadow_we;
  logic [FIR_TAP_WIDTH-1:0] shadow_q [FIR_TAP_NUM];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      ds_lat_q   <= '0;
      ds_q       <= '0;
      tap_vld_q  <= 1'b0;
      tap_addr_q <= '0;
      tap_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      ds_lat_q   <= ds_lat_d;
      ds_q       <= ds_d;
      tap_vld_q  <= tap_vld_d;
      tap_addr_q <= tap_addr_d;
      tap_data_q <= tap_data_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    ds_lat_d   = ds_lat_q;
    ds_d       = ds_q;
    tap_vld_d  = 1'b0;
    tap_addr_d = tap_addr_q;
    tap_data_d = tap_data_q;
    err_d      = 1'b0;
    shadow_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_wr_i) begin
          if (cfg_addr_i < TAP_NUM_L) shadow_we = 1'b1;
          else                        err_d     = 1'b1;
        end
        if (cfg_commit_i) begin
          state_d  = DRAIN;
          cnt_d    = '0;
          ds_lat_d = (cfg_ds_i > DS_MAX_L) ? DS_MAX_L : cfg_ds_i;
        end
      end
      DRAIN: begin
        if (fir_m_tvalid_i)        cnt_d = '0;
        else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // Tap 0 is issued on the exit edge so the first strobe lands right after drain.
        if (cnt_d == CNT_MAX) begin
          state_d    = LOAD;
          tap_vld_d  = 1'b1;
          tap_addr_d = '0;
          tap_data_d = shadow_q[0];
          idx_d      = 10'd1;
        end
      end
      LOAD: begin
        if (idx_q < TAP_NUM_L) begin
          tap_vld_d  = 1'b1;
          tap_addr_d = idx_q;
          tap_data_d = shadow_q[idx_q[AW-1:0]];
          idx_d      = idx_q + 10'd1;
        end else begin
          state_d = DSUPD;
          ds_d    = ds_lat_q;
        end
      end
      DSUPD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && (cfg_wr_i || cfg_commit_i)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIR_TAP_NUM; i++) shadow_q[i] <= '0;
    end else if (shadow_we) begin
      shadow_q[cfg_addr_i[AW-1:0]] <= cfg_data_i;
    end
  end

`ifdef FIR_CFG_READBACK_EN
  logic [FIR_TAP_WIDTH-1:0] rd_data_q;
  always_ff @(posedge clk_i) begin
    if (rst_i)                       rd_data_q <= '0;
    else if (rd_addr_i < TAP_NUM_L)  rd_data_q <= shadow_q[rd_addr_i[AW-1:0]];
    else                             rd_data_q <= '0;
  end
  assign rd_data_o = rd_data_q;
`endif

  // Upstream stream passes straight through only while no reconfiguration is running.
  assign fir_s_tvalid_o        = (state_q == IDLE) && s_axis_tvalid_i;
  assign s_axis_tready_o       = (state_q == IDLE) && fir_s_tready_i;
  assign busy_o                = (state_q != IDLE);
  assign done_o                = (state_q == DSUPD);
  assign err_o                 = err_q;
  assign fir_tap_vld_o         = tap_vld_q;
  assign fir_tap_addr_o        = tap_addr_q;
  assign fir_tap_data_o        = tap_data_q;
  assign fir_down_sample_num_o = ds_q;

endmodule

// File: tb/tb_fir_cfg_ctrl.sv
// tb/tb_fir_cfg_ctrl.sv - directed self-checking bench for fir_cfg_ctrl
// Optional readback checks follow FIR_CFG_READBACK_EN.
module tb_fir_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cfg_wr_i = 1'b0;
  logic [9:0]  cfg_addr_i = '0;
  logic [31:0] cfg_data_i = '0;
  logic [7:0]  cfg_ds_i = '0;
  logic        cfg_commit_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic        s_axis_tvalid_i = 1'b0;
  logic        s_axis_tready_o, fir_s_tvalid_o;
  logic        fir_s_tready_i = 1'b0;
  logic        fir_m_tvalid_i = 1'b0;
  logic        fir_tap_vld_o;
  logic [9:0]  fir_tap_addr_o;
  logic [31:0] fir_tap_data_o;
  logic [7:0]  fir_down_sample_num_o;
`ifdef FIR_CFG_READBACK_EN
  logic [9:0]  rd_addr_i = '0;
  logic [31:0] rd_data_o;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int commit_cyc = 0;

  fir_cfg_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_wr_i(cfg_wr_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .cfg_ds_i(cfg_ds_i), .cfg_commit_i(cfg_commit_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .s_axis_tvalid_i(s_axis_tvalid_i), .s_axis_tready_o(s_axis_tready_o),
    .fir_s_tvalid_o(fir_s_tvalid_o), .fir_s_tready_i(fir_s_tready_i),
    .fir_m_tvalid_i(fir_m_tvalid_i),
    .fir_tap_vld_o(fir_tap_vld_o), .fir_tap_addr_o(fir_tap_addr_o),
    .fir_tap_data_o(fir_tap_data_o),
`ifdef FIR_CFG_READBACK_EN
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
`endif
    .fir_down_sample_num_o(fir_down_sample_num_o)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Negedge monitor: records strobes, pulses and gating violations per scenario.
  int          clr_tok = 0, clr_seen = 0;
  int          strobe_n, first_cyc, last_cyc, done_n, done_cyc, err_n, gate_viol, fall_cyc;
  logic [7:0]  done_ds, ds_at_last;
  logic        busy_prev = 1'b0;
  logic [9:0]  s_addr [$];
  logic [31:0] s_data [$];

  always @(negedge clk) begin
    if (clr_tok != clr_seen) begin
      clr_seen = clr_tok;
      strobe_n = 0; first_cyc = -1; last_cyc = -1; done_n = 0; done_cyc = -1;
      err_n = 0; gate_viol = 0; fall_cyc = -1; done_ds = '0; ds_at_last = '0;
      s_addr.delete(); s_data.delete();
    end
    if (fir_tap_vld_o === 1'b1) begin
      if (strobe_n == 0) first_cyc = cyc;
      last_cyc = cyc;
      s_addr.push_back(fir_tap_addr_o);
      s_data.push_back(fir_tap_data_o);
      ds_at_last = fir_down_sample_num_o;
      strobe_n++;
    end
    if (done_o === 1'b1) begin done_n++; done_cyc = cyc; done_ds = fir_down_sample_num_o; end
    if (err_o === 1'b1) err_n++;
    if (busy_o === 1'b1 && (fir_s_tvalid_o !== 1'b0 || s_axis_tready_o !== 1'b0)) gate_viol++;
    if (busy_prev && busy_o === 1'b0 && fall_cyc < 0) fall_cyc = cyc;
    busy_prev = (busy_o === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr_tok++;
  endtask

  task automatic do_commit(input logic [7:0] ds);
    cfg_ds_i = ds;
    cfg_commit_i = 1'b1;
    commit_cyc = cyc;
    step();
    cfg_commit_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) step();
    checks++; if ({busy_o, done_o, err_o, fir_tap_vld_o} !== 4'b0) begin errors++;
      $display("FAIL reset_flags: got %b want 0000", {busy_o, done_o, err_o, fir_tap_vld_o}); end
    checks++; if (fir_tap_addr_o !== 10'd0 || fir_tap_data_o !== 32'd0 || fir_down_sample_num_o !== 8'd0) begin errors++;
      $display("FAIL reset_data: addr %0d data %h ds %0d want 0", fir_tap_addr_o, fir_tap_data_o, fir_down_sample_num_o); end
    rst_i = 1'b0;
    s_axis_tvalid_i = 1'b1; fir_s_tready_i = 1'b1; #1;
    checks++; if (fir_s_tvalid_o !== 1'b1 || s_axis_tready_o !== 1'b1) begin errors++;
      $display("FAIL idle_pass_hi: tvalid %b tready %b want 1 1", fir_s_tvalid_o, s_axis_tready_o); end
    s_axis_tvalid_i = 1'b0; fir_s_tready_i = 1'b0; #1;
    checks++; if (fir_s_tvalid_o !== 1'b0 || s_axis_tready_o !== 1'b0) begin errors++;
      $display("FAIL idle_pass_lo: tvalid %b tready %b want 0 0", fir_s_tvalid_o, s_axis_tready_o); end
    step();
  endtask

  task automatic test_normal_reload();
    int bad = 0;
    clear_mon();
    for (int i = 0; i < 78; i++) begin
      cfg_wr_i = 1'b1; cfg_addr_i = 10'(i); cfg_data_i = 32'h100 + 32'(i);
      step();
    end
    cfg_addr_i = 10'd78; cfg_data_i = 32'h14E;
    do_commit(8'd4);
    cfg_wr_i = 1'b0;
    for (int i = 0; i < 300 && busy_o !== 1'b0; i++) step();
    step();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL normal_timeout: busy %b want 0", busy_o); end
    checks++; if (strobe_n !== 79) begin errors++; $display("FAIL normal_count: got %0d want 79", strobe_n); end
    checks++; if (first_cyc !== commit_cyc + 65) begin errors++;
      $display("FAIL normal_first: got %0d want %0d", first_cyc - commit_cyc, 65); end
    checks++; if (last_cyc !== first_cyc + 78) begin errors++;
      $display("FAIL normal_contig: last-first %0d want 78", last_cyc - first_cyc); end
    for (int j = 0; j < s_addr.size(); j++)
      if (s_addr[j] !== 10'(j) || s_data[j] !== 32'h100 + 32'(j)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL normal_taps: %0d wrong want 0", bad); end
    checks++; if (done_n !== 1 || done_cyc !== last_cyc + 1) begin errors++;
      $display("FAIL normal_done: n %0d offset %0d want 1 1", done_n, done_cyc - last_cyc); end
    checks++; if (done_ds !== 8'd4 || ds_at_last !== 8'd0) begin errors++;
      $display("FAIL normal_ds: at done %0d at last tap %0d want 4 0", done_ds, ds_at_last); end
    checks++; if (fall_cyc !== done_cyc + 1) begin errors++;
      $display("FAIL normal_busy_fall: offset %0d want 1", fall_cyc - done_cyc); end
    checks++; if (err_n !== 0) begin errors++; $display("FAIL normal_err: got %0d want 0", err_n); end
    checks++; if (fir_tap_addr_o !== 10'd78 || fir_tap_data_o !== 32'h14E) begin errors++;
      $display("FAIL tap_hold: addr %0d data %h want 78 14e", fir_tap_addr_o, fir_tap_data_o); end
`ifdef FIR_CFG_READBACK_EN
    rd_addr_i = 10'd10; step(); #1;
    checks++; if (rd_data_o !== 32'h10A) begin errors++; $display("FAIL rd_10: got %h want 10a", rd_data_o); end
    rd_addr_i = 10'd79; step(); #1;
    checks++; if (rd_data_o !== 32'h0) begin errors++; $display("FAIL rd_79: got %h want 0", rd_data_o); end
`endif
  endtask

  task automatic test_drain_restart();
    clear_mon();
    do_commit(8'd4);
    for (int i = 0; i < 100 && cyc < commit_cyc + 31; i++) step();
    fir_m_tvalid_i = 1'b1;
    step();
    fir_m_tvalid_i = 1'b0;
    for (int i = 0; i < 300 && busy_o !== 1'b0; i++) step();
    step();
    checks++; if (first_cyc !== commit_cyc + 96) begin errors++;
      $display("FAIL restart_first: got %0d want 96", first_cyc - commit_cyc); end
    checks++; if (strobe_n !== 79 || done_ds !== 8'd4) begin errors++;
      $display("FAIL restart_load: count %0d ds %0d want 79 4", strobe_n, done_ds); end
  endtask

  task automatic test_errors();
    int bad = 0;
    clear_mon();
    cfg_wr_i = 1'b1; cfg_addr_i = 10'd79; cfg_data_i = 32'hDEAD_BEEF;
    step();
    cfg_wr_i = 1'b0;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_addr_pulse: got %b want 1", err_o); end
    step();
    checks++; if (err_n !== 1) begin errors++; $display("FAIL err_addr_count: got %0d want 1", err_n); end
    do_commit(8'd7);
    for (int i = 0; i < 200 && fir_tap_vld_o !== 1'b1; i++) step();
    repeat (3) step();
    cfg_ds_i = 8'd2; cfg_commit_i = 1'b1; step(); cfg_commit_i = 1'b0;
    repeat (5) step();
    cfg_wr_i = 1'b1; cfg_addr_i = 10'd3; cfg_data_i = 32'hBAD; step(); cfg_wr_i = 1'b0;
    for (int i = 0; i < 300 && busy_o !== 1'b0; i++) step();
    repeat (3) step();
    checks++; if (err_n !== 3) begin errors++; $display("FAIL err_total: got %0d want 3", err_n); end
    for (int j = 0; j < s_addr.size(); j++)
      if (s_addr[j] !== 10'(j) || s_data[j] !== 32'h100 + 32'(j)) bad++;
    checks++; if (strobe_n !== 79 || bad !== 0 || first_cyc !== commit_cyc + 65) begin errors++;
      $display("FAIL err_load: count %0d bad %0d first %0d want 79 0 65", strobe_n, bad, first_cyc - commit_cyc); end
    checks++; if (done_n !== 1 || done_ds !== 8'd7) begin errors++;
      $display("FAIL err_done: n %0d ds %0d want 1 7", done_n, done_ds); end
  endtask

  task automatic test_clamp_gating();
    int bad = 0;
    clear_mon();
    s_axis_tvalid_i = 1'b1; fir_s_tready_i = 1'b1;
    do_commit(8'd25);
    for (int i = 0; i < 300 && busy_o !== 1'b0; i++) step();
    #1;
    checks++; if (fir_s_tvalid_o !== 1'b1 || s_axis_tready_o !== 1'b1) begin errors++;
      $display("FAIL gate_resume: tvalid %b tready %b want 1 1", fir_s_tvalid_o, s_axis_tready_o); end
    step();
    checks++; if (gate_viol !== 0) begin errors++; $display("FAIL gate_busy: %0d cycles want 0", gate_viol); end
    checks++; if (done_ds !== 8'd19) begin errors++; $display("FAIL clamp_ds: got %0d want 19", done_ds); end
    for (int j = 0; j < s_addr.size(); j++)
      if (s_data[j] !== 32'h100 + 32'(j)) bad++;
    checks++; if (strobe_n !== 79 || bad !== 0) begin errors++;
      $display("FAIL shadow_kept: count %0d bad %0d want 79 0", strobe_n, bad); end
    s_axis_tvalid_i = 1'b0; fir_s_tready_i = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    int bad = 0;
    clear_mon();
    do_commit(8'd4);
    for (int i = 0; i < 200 && !(fir_tap_vld_o === 1'b1 && fir_tap_addr_o == 10'd40); i++) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    checks++; if ({busy_o, done_o, err_o, fir_tap_vld_o} !== 4'b0) begin errors++;
      $display("FAIL rst_load_flags: got %b want 0000", {busy_o, done_o, err_o, fir_tap_vld_o}); end
    checks++; if (fir_tap_addr_o !== 10'd0 || fir_tap_data_o !== 32'd0 || fir_down_sample_num_o !== 8'd0) begin errors++;
      $display("FAIL rst_load_data: addr %0d data %h ds %0d want 0", fir_tap_addr_o, fir_tap_data_o, fir_down_sample_num_o); end
`ifdef FIR_CFG_READBACK_EN
    rd_addr_i = 10'd5; step(); #1;
    checks++; if (rd_data_o !== 32'h0) begin errors++; $display("FAIL rd_after_rst: got %h want 0", rd_data_o); end
`endif
    repeat (100) step();
    checks++; if (strobe_n !== 41) begin errors++; $display("FAIL rst_no_more_taps: got %0d want 41", strobe_n); end
    clear_mon();
    do_commit(8'd1);
    for (int i = 0; i < 300 && busy_o !== 1'b0; i++) step();
    step();
    for (int j = 0; j < s_data.size(); j++)
      if (s_data[j] !== 32'h0) bad++;
    checks++; if (strobe_n !== 79 || bad !== 0 || done_ds !== 8'd1) begin errors++;
      $display("FAIL rst_shadow_zero: count %0d bad %0d ds %0d want 79 0 1", strobe_n, bad, done_ds); end
  endtask

  initial begin
    test_reset();
    test_normal_reload();
    test_drain_restart();
    test_errors();
    test_clamp_gating();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
